vend_sequencer: RTL and testbench

Transaction controller for the vending machine. Accepts coins, item purchases and cancels from the front panel, keeps the customer and machine balances, and sequences every update of the money store: a write strobe with mode 0 writes machine money, mode 1 writes customer money. Also drives dispense and change outputs toward the delivery logic. One transaction is in flight at a time.

---
 rtl/vend_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_vend_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// vend_sequencer: vending machine transaction controller.
// Accepts coins, purchases and cancels while IDLE. It keeps the customer and
// machine balances and sequences the money-store writes:
// mode 0 = machine money, mode 1 = customer money.
// It also drives the dispense and change pulses toward the delivery logic.
// Only one transaction is in flight at a time.
//
// Optional feature: define VEND_TIMEOUT_EN to enable an idle auto-refund.
// After TIMEOUT idle cycles with a non-zero customer balance, the block runs
// the same sequence as a cancel.
module vend_sequencer #(
    parameter int                WIDTH        = 4,
    parameter logic [WIDTH-1:0]  INIT_MACHINE = '0
`ifdef VEND_TIMEOUT_EN
    ,
    parameter int                TIMEOUT      = 255
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             coin_valid,
    input  logic [WIDTH-1:0] coin_value,
    output logic             coin_ready,
    output logic             coin_reject,
    input  logic             item_req,
    input  logic [WIDTH-1:0] item_price,
    input  logic             cancel,
    output logic             store_write,
    output logic             store_mode,
    output logic [WIDTH-1:0] store_value,
    output logic             dispense,
    output logic             change_valid,
    output logic [WIDTH-1:0] change_value,
    output logic             deny,
    output logic             fault,
    output logic             busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_COIN = 3'd1;
    localparam logic [2:0] S_WR_MACH = 3'd2;
    localparam logic [2:0] S_WR_CUST = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [WIDTH-1:0] r_cust_bal;
    logic [WIDTH-1:0] r_mach_bal;
    logic [WIDTH-1:0] r_change;     // change or refund presented in DONE
    logic             r_vend;       // DONE of a purchase (dispense) vs a refund
    logic             r_deny;
    logic             r_fault;
    logic             r_coin_reject;

    // One extra bit so overflow is detected instead of wrapping.
    logic [WIDTH:0]   w_coin_sum;
    logic [WIDTH:0]   w_mach_sum;
    logic             w_idle;
    logic             w_cancel;
    logic             w_timeout;
    logic             w_do_cancel;
    logic             w_item;
    logic             w_price_ok;
    logic             w_mach_ok;
    logic             w_buy;
    logic             w_coin;
    logic             w_coin_ok;
    logic             w_coin_go;

    assign w_coin_sum = {1'b0, r_cust_bal} + {1'b0, coin_value};
    assign w_mach_sum = {1'b0, r_mach_bal} + {1'b0, item_price};

    assign w_idle      = (r_state == S_IDLE);

    // Requests are only looked at in IDLE. The priority order is
    // cancel, then item_req, then coin.
    assign w_cancel    = w_idle & cancel;
    assign w_do_cancel = w_cancel | w_timeout;
    assign w_item      = w_idle & item_req & ~cancel;
    assign w_price_ok  = (item_price <= r_cust_bal);
    assign w_mach_ok   = ~w_mach_sum[WIDTH];
    assign w_buy       = w_item & w_price_ok & w_mach_ok;
    assign w_coin      = w_idle & coin_valid & ~cancel & ~item_req;
    assign w_coin_ok   = ~w_coin_sum[WIDTH];
    assign w_coin_go   = w_coin & w_coin_ok;

`ifdef VEND_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_idle_cnt;
    logic          w_any_req;

    assign w_any_req = cancel | item_req | coin_valid;

    // The timeout only fires when nothing else is asking.
    // Any request in that cycle takes precedence.
    assign w_timeout = w_idle & (r_cust_bal != '0) & ~w_any_req
                       & (r_idle_cnt == TW'(TIMEOUT));

    // Idle counter: runs in IDLE while money is held.
    // It restarts on any handshaken coin and whenever IDLE is left.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (!w_idle || w_coin || (r_cust_bal == '0)) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != TW'(TIMEOUT)) begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state logic for the transaction sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_do_cancel) begin
                    w_state_next = S_WR_CUST;
                end else if (w_buy) begin
                    w_state_next = S_WR_MACH;
                end else if (w_coin_go) begin
                    w_state_next = S_WR_COIN;
                end
            end
            S_WR_COIN: w_state_next = S_IDLE;
            S_WR_MACH: w_state_next = S_WR_CUST;
            S_WR_CUST: w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Balances and the latched change amount.
    // They update at the accepting edge, so the write states only present them.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cust_bal <= '0;
            r_mach_bal <= INIT_MACHINE;
            r_change   <= '0;
            r_vend     <= 1'b0;
        end else if (w_do_cancel) begin
            r_change   <= r_cust_bal;
            r_cust_bal <= '0;
            r_vend     <= 1'b0;
        end else if (w_buy) begin
            r_change   <= r_cust_bal - item_price;
            r_mach_bal <= w_mach_sum[WIDTH-1:0];
            r_cust_bal <= '0;
            r_vend     <= 1'b1;
        end else if (w_coin_go) begin
            r_cust_bal <= w_coin_sum[WIDTH-1:0];
        end
    end

    // Refusal pulses, asserted for the one cycle after the request.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_deny        <= 1'b0;
            r_fault       <= 1'b0;
            r_coin_reject <= 1'b0;
        end else begin
            r_deny        <= w_item & ~w_price_ok;
            r_fault       <= w_item & w_price_ok & ~w_mach_ok;
            r_coin_reject <= w_coin & ~w_coin_ok;
        end
    end

    // Store port is decoded from the state. Mode and value stay 0 without a
    // strobe. Reset masks it so an aborted sequence emits nothing.
    always_comb begin
        store_write = 1'b0;
        store_mode  = 1'b0;
        store_value = '0;
        if (!reset) begin
            case (r_state)
                S_WR_COIN: begin
                    store_write = 1'b1;
                    store_mode  = 1'b1;
                    store_value = r_cust_bal;
                end
                S_WR_MACH: begin
                    store_write = 1'b1;
                    store_mode  = 1'b0;
                    store_value = r_mach_bal;
                end
                S_WR_CUST: begin
                    store_write = 1'b1;
                    store_mode  = 1'b1;
                    store_value = '0;
                end
                default: begin
                    store_write = 1'b0;
                    store_mode  = 1'b0;
                    store_value = '0;
                end
            endcase
        end
    end

    assign coin_ready   = ~reset & w_idle;
    assign busy         = ~reset & ~w_idle;
    assign change_valid = ~reset & (r_state == S_DONE);
    assign dispense     = change_valid & r_vend;
    assign change_value = change_valid ? r_change : '0;
    assign deny         = ~reset & r_deny;
    assign fault        = ~reset & r_fault;
    assign coin_reject  = ~reset & r_coin_reject;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer (WIDTH = 4, INIT_MACHINE = 2).
// With VEND_TIMEOUT_EN defined, it also exercises the auto-refund (TIMEOUT = 10).
module tb_vend_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [3:0] coin_value = '0;
    logic       coin_ready;
    logic       coin_reject;
    logic       item_req = 1'b0;
    logic [3:0] item_price = '0;
    logic       cancel = 1'b0;
    logic       store_write;
    logic       store_mode;
    logic [3:0] store_value;
    logic       dispense;
    logic       change_valid;
    logic [3:0] change_value;
    logic       deny;
    logic       fault;
    logic       busy;

    int n_cmp = 0;
    int n_mis = 0;

    vend_sequencer #(
        .WIDTH        (4),
        .INIT_MACHINE (4'd2)
`ifdef VEND_TIMEOUT_EN
        ,
        .TIMEOUT      (10)
`endif
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .coin_ready   (coin_ready),
        .coin_reject  (coin_reject),
        .item_req     (item_req),
        .item_price   (item_price),
        .cancel       (cancel),
        .store_write  (store_write),
        .store_mode   (store_mode),
        .store_value  (store_value),
        .dispense     (dispense),
        .change_valid (change_valid),
        .change_value (change_value),
        .deny         (deny),
        .fault        (fault),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Store port packed as {write, mode, value}.
    task automatic chk_store(input string tag, input int w, input int m, input int v);
        chk(tag, {26'd0, store_write, store_mode, store_value}, (w << 5) | (m << 4) | v);
    endtask

    task automatic do_coin(input string tag, input int v, input int exp_bal);
        coin_valid = 1'b1;
        coin_value = 4'(v);
        tick();
        coin_valid = 1'b0;
        chk_store({tag, "_write"}, 1, 1, exp_bal);
        chk({tag, "_ready_low"}, int'(coin_ready), 0);
        tick();
        chk({tag, "_ready_high"}, int'(coin_ready), 1);
        $display("txn %s coin=%0d cust_bal=%0d", tag, v, exp_bal);
    endtask

    task automatic do_buy(input string tag, input int price, input int exp_mach, input int exp_chg);
        item_req   = 1'b1;
        item_price = 4'(price);
        tick();
        item_req = 1'b0;
        chk_store({tag, "_mach_wr"}, 1, 0, exp_mach);
        tick();
        chk_store({tag, "_cust_wr"}, 1, 1, 0);
        tick();
        chk({tag, "_dispense"}, int'(dispense), 1);
        chk({tag, "_chg_valid"}, int'(change_valid), 1);
        chk({tag, "_chg_value"}, int'(change_value), exp_chg);
        chk_store({tag, "_no_wr"}, 0, 0, 0);
        tick();
        chk({tag, "_idle"}, int'(busy), 0);
        $display("txn %s price=%0d mach=%0d change=%0d", tag, price, exp_mach, exp_chg);
    endtask

    task automatic do_cancel(input string tag, input logic with_item, input int exp_ref);
        cancel     = 1'b1;
        item_req   = with_item;
        item_price = 4'd1;
        tick();
        cancel   = 1'b0;
        item_req = 1'b0;
        chk_store({tag, "_cust_wr"}, 1, 1, 0);
        tick();
        chk({tag, "_chg_valid"}, int'(change_valid), 1);
        chk({tag, "_chg_value"}, int'(change_value), exp_ref);
        chk({tag, "_no_disp"}, int'(dispense), 0);
        tick();
        chk({tag, "_idle"}, int'(busy), 0);
        $display("txn %s refund=%0d", tag, exp_ref);
    endtask

    initial begin
        // Reset: every output low while reset is held.
        tick();
        tick();
        chk("rst_ready", int'(coin_ready), 0);
        chk_store("rst_store", 0, 0, 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_chg", int'(change_valid), 0);
        reset = 1'b0;
        #1;
        chk("rst_release_ready", int'(coin_ready), 1);
        $display("txn reset released");

        do_coin("coin5", 5, 5);
        do_coin("coin3", 3, 8);
        do_buy("buy6", 6, 8, 2);                 // cust 8, mach 2 -> mach 8, change 2

        do_coin("coin4", 4, 4);
        item_req   = 1'b1;
        item_price = 4'd6;
        tick();
        item_req = 1'b0;
        chk("deny_pulse", int'(deny), 1);
        chk_store("deny_no_wr", 0, 0, 0);
        chk("deny_busy", int'(busy), 0);
        tick();
        chk("deny_clear", int'(deny), 0);
        $display("txn deny price=6 cust=4");

        do_buy("buy4", 4, 12, 0);                // mach 12, cust 0
        do_coin("coin8", 8, 8);
        item_req   = 1'b1;
        item_price = 4'd6;                       // 12 + 6 > 15
        tick();
        item_req = 1'b0;
        chk("fault_pulse", int'(fault), 1);
        chk("fault_no_deny", int'(deny), 0);
        chk_store("fault_no_wr", 0, 0, 0);
        tick();
        chk("fault_clear", int'(fault), 0);
        $display("txn fault price=6 mach=12");
        do_coin("coin1", 1, 9);                  // customer balance kept at 8

        do_cancel("cancel_item", 1'b1, 9);       // cancel wins over item_req

        do_coin("coin14", 14, 14);
        coin_valid = 1'b1;
        coin_value = 4'd3;
        tick();
        coin_valid = 1'b0;
        chk("reject_pulse", int'(coin_reject), 1);
        chk_store("reject_no_wr", 0, 0, 0);
        chk("reject_ready", int'(coin_ready), 1);
        tick();
        chk("reject_clear", int'(coin_reject), 0);
        $display("txn coin_reject coin=3 cust=14");
        do_coin("coin1_max", 1, 15);             // reaches MAX exactly

        do_buy("buy3_max", 3, 15, 12);           // mach 12 unchanged by fault, now MAX
        do_coin("coin0", 0, 0);
        do_cancel("cancel_zero", 1'b0, 0);

        // Requests while busy are dropped.
        coin_valid = 1'b1;
        coin_value = 4'd2;
        tick();
        cancel     = 1'b1;
        item_req   = 1'b1;
        item_price = 4'd0;
        chk_store("busy_coin_wr", 1, 1, 2);
        tick();
        coin_valid = 1'b0;
        cancel     = 1'b0;
        item_req   = 1'b0;
        chk("busy_ignored_idle", int'(busy), 0);
        chk_store("busy_ignored_no_wr", 0, 0, 0);
        tick();
        chk("busy_ignored_no_chg", int'(change_valid), 0);
        $display("txn busy inputs ignored");

        // Reset during WR_MACH aborts the purchase.
        item_req   = 1'b1;
        item_price = 4'd0;
        tick();
        item_req = 1'b0;
        chk_store("abort_mach_wr", 1, 0, 15);
        reset = 1'b1;
        #1;
        chk_store("abort_masked", 0, 0, 0);
        tick();
        chk("abort_ready_low", int'(coin_ready), 0);
        chk("abort_no_disp", int'(dispense), 0);
        reset = 1'b0;
        #1;
        chk("abort_ready_high", int'(coin_ready), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_wr", int'(store_write), 0);
            chk("abort_no_chg", int'(change_valid | dispense), 0);
        end
        $display("txn reset during WR_MACH");
        do_coin("post_rst_coin", 1, 1);          // cust reloaded to 0
        do_buy("post_rst_buy", 1, 3, 0);         // mach reloaded to 2

`ifdef VEND_TIMEOUT_EN
        begin
            int wr_at  = -1;
            int chg_at = -1;
            do_coin("to_coin3", 3, 3);
            repeat (9) tick();
            do_coin("to_restart", 0, 3);          // coin at idle cycle 9 restarts the count
            for (int i = 1; i <= 30 && chg_at < 0; i++) begin
                tick();
                if (store_write) begin
                    wr_at = i;
                    chk_store("to_refund_wr", 1, 1, 0);
                end
                if (change_valid) begin
                    chg_at = i;
                    chk("to_refund_value", int'(change_value), 3);
                end
            end
            chk("to_wr_cycle", wr_at, 11);
            chk("to_chg_cycle", chg_at, 12);
            $display("txn timeout refund=3");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
